// File: rtl/rpn_sequencer.sv
// rpn_sequencer: runs RPN ops as push/pop/replace pulses on an external stack.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_num
// command in; stk_push/stk_pop/stk_replace/stk_in_num stack control;
// stk_size/stk_top/stk_error/stk_vld stack status; done/err_code result.
// Define RPN_MUL_EN to build MUL (opcode 011); without it MUL is illegal.
module rpn_sequencer #(
  parameter int DEPTH = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_num,
  output logic        stk_push,
  output logic        stk_pop,
  output logic        stk_replace,
  output logic [31:0] stk_in_num,
  input  logic [9:0]  stk_size,
  input  logic [31:0] stk_top,
  input  logic        stk_error,
  input  logic        stk_vld,
  output logic        done,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT1,
    S_WAITV,
    S_LATCHB,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    C_NONE,
    C_PUSH,
    C_POP,
    C_REPL
  } cmd_e;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_POP  = 3'b100;
  localparam logic [2:0] OP_DUP  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_NEG  = 3'b111;

  localparam logic [1:0] E_OK  = 2'b00;
  localparam logic [1:0] E_UND = 2'b01;
  localparam logic [1:0] E_OVF = 2'b10;
  localparam logic [1:0] E_ILL = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] num_q, num_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  err_q, err_d;

  logic        accept;
  logic        full;
  logic [1:0]  chk_err;
  logic [1:0]  n_steps;
  cmd_e        step_cmd;
  cmd_e        cmd;
  logic [31:0] step_val;

  assign cmd_ready = !reset && (state_q == S_IDLE) && stk_vld;
  assign accept    = cmd_valid && cmd_ready;
  assign full      = ({22'd0, stk_size} == 32'(DEPTH));

  // Precheck on the live stack status in the acceptance cycle.
  always_comb begin
    chk_err = E_OK;
    case (cmd_op)
      OP_PUSH: if (full) chk_err = E_OVF;
      OP_POP, OP_NEG:
        if (stk_size == 10'd0) chk_err = E_UND;
      OP_DUP:
        if (stk_size == 10'd0) chk_err = E_UND;
        else if (full) chk_err = E_OVF;
`ifdef RPN_MUL_EN
      OP_ADD, OP_SUB, OP_MUL, OP_SWAP:
        if (stk_size < 10'd2) chk_err = E_UND;
`else
      OP_MUL: chk_err = E_ILL;
      OP_ADD, OP_SUB, OP_SWAP:
        if (stk_size < 10'd2) chk_err = E_UND;
`endif
      default: chk_err = E_ILL;
    endcase
  end

  // Number of stack commands each op needs.
  always_comb begin
    n_steps = 2'd1;
    case (op_q)
      OP_ADD, OP_SUB, OP_MUL: n_steps = 2'd2;
      OP_SWAP:                n_steps = 2'd3;
      default:                n_steps = 2'd1;
    endcase
  end

  // Command and operand for the current step.
  always_comb begin
    step_cmd = C_NONE;
    step_val = '0;
    case (step_q)
      2'd0: begin
        case (op_q)
          OP_PUSH: begin
            step_cmd = C_PUSH;
            step_val = num_q;
          end
          OP_POP: step_cmd = C_POP;
          OP_DUP: begin
            step_cmd = C_PUSH;
            step_val = a_q;
          end
          OP_NEG: begin
            step_cmd = C_REPL;
            step_val = 32'd0 - a_q;
          end
          default: step_cmd = C_POP;
        endcase
      end
      2'd1: begin
        step_cmd = C_REPL;
        case (op_q)
          OP_ADD: step_val = b_q + a_q;
          OP_SUB: step_val = b_q - a_q;
`ifdef RPN_MUL_EN
          OP_MUL: step_val = b_q * a_q;
`endif
          // SWAP: old top goes into the deeper slot
          default: step_val = a_q;
        endcase
      end
      2'd2: begin
        step_cmd = C_PUSH;
        step_val = b_q;
      end
      default: step_cmd = C_NONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    num_d   = num_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    cmd     = C_NONE;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          num_d   = cmd_num;
          a_d     = stk_top;
          step_d  = 2'd0;
          err_d   = chk_err;
          state_d = (chk_err == E_OK) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (stk_vld) begin
          cmd     = step_cmd;
          step_d  = step_q + 2'd1;
          state_d = S_WAIT1;
        end
      end
      S_WAIT1: state_d = S_WAITV;
      S_WAITV: begin
        if (stk_vld) begin
          if (step_q == n_steps) begin
            state_d = S_DONE;
            if (stk_error) err_d = E_ILL;
          end else if (step_q == 2'd1) begin
            state_d = S_LATCHB;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_LATCHB: begin
        b_d     = stk_top;
        state_d = S_ISSUE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      op_q    <= OP_PUSH;
      num_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= E_OK;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      num_q   <= num_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  assign stk_push    = !reset && (cmd == C_PUSH);
  assign stk_pop     = !reset && (cmd == C_POP);
  assign stk_replace = !reset && (cmd == C_REPL);
  assign stk_in_num  = step_val;
  assign done        = !reset && (state_q == S_DONE);
  assign err_code    = err_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer: drives rpn_sequencer against a behavioural stack
// and a queue-based RPN reference model.
module tb_rpn_sequencer;

  localparam int DEPTH = 512;
`ifdef RPN_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [2:0] PUSH = 3'd0;
  localparam logic [2:0] ADD  = 3'd1;
  localparam logic [2:0] SUB  = 3'd2;
  localparam logic [2:0] MUL  = 3'd3;
  localparam logic [2:0] POP  = 3'd4;
  localparam logic [2:0] DUP  = 3'd5;
  localparam logic [2:0] SWAP = 3'd6;
  localparam logic [2:0] NEG  = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_num = 32'd0;
  logic        stk_push, stk_pop, stk_replace;
  logic [31:0] stk_in_num;
  logic [9:0]  stk_size;
  logic [31:0] stk_top;
  logic        stk_error;
  logic        stk_vld;
  logic        done;
  logic [1:0]  err_code;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rpn_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_num     (cmd_num),
    .stk_push    (stk_push),
    .stk_pop     (stk_pop),
    .stk_replace (stk_replace),
    .stk_in_num  (stk_in_num),
    .stk_size    (stk_size),
    .stk_top     (stk_top),
    .stk_error   (stk_error),
    .stk_vld     (stk_vld),
    .done        (done),
    .err_code    (err_code)
  );

  // Behavioural stack: busy for lat cycles after each command.
  logic [31:0] mem [0:DEPTH-1];
  int   sp = 0;
  int   busy = 0;
  logic serr = 1'b0;
  logic inj_err = 1'b0;
  int   fixed_lat = 0;

  assign stk_vld   = (busy == 0);
  assign stk_size  = sp[9:0];
  assign stk_top   = (sp > 0) ? mem[sp-1] : 32'd0;
  assign stk_error = serr | inj_err;

  always @(posedge clk) begin
    if (reset) begin
      sp   <= 0;
      busy <= 0;
      serr <= 1'b0;
    end else if (stk_push | stk_pop | stk_replace) begin
      busy <= (fixed_lat > 0) ? fixed_lat
                              : int'($urandom_range(1, 3));
      serr <= 1'b0;
      if (stk_push) begin
        if (sp == DEPTH) serr <= 1'b1;
        else begin
          mem[sp] <= stk_in_num;
          sp <= sp + 1;
        end
      end else if (stk_pop) begin
        if (sp == 0) serr <= 1'b1;
        else sp <= sp - 1;
      end else begin
        if (sp == 0) serr <= 1'b1;
        else mem[sp-1] <= stk_in_num;
      end
    end else if (busy > 0) begin
      busy <= busy - 1;
    end
  end

  // Command monitor: 1=push 2=pop 3=replace
  int          log_q[$];
  logic [31:0] logv_q[$];
  int          viol = 0;

  always @(posedge clk) begin
    if (!reset) begin
      if ((int'(stk_push) + int'(stk_pop) + int'(stk_replace) > 1) ||
          ((stk_push | stk_pop | stk_replace) && !stk_vld))
        viol <= viol + 1;
      if (stk_push) begin
        log_q.push_back(1);
        logv_q.push_back(stk_in_num);
      end
      if (stk_pop) begin
        log_q.push_back(2);
        logv_q.push_back(stk_in_num);
      end
      if (stk_replace) begin
        log_q.push_back(3);
        logv_q.push_back(stk_in_num);
      end
    end
  end

  // Reference RPN machine.
  logic [31:0] rq[$];

  task automatic ref_apply(input logic [2:0] op, input logic [31:0] num,
                           output logic [1:0] e, output int n);
    logic [31:0] a, b;
    int sz;
    sz = rq.size();
    e = 2'b00;
    n = 0;
    if (op == MUL && !MUL_EN) e = 2'b11;
    else if ((op inside {ADD, SUB, MUL, SWAP} && sz < 2) ||
             (op inside {POP, DUP, NEG} && sz < 1)) e = 2'b01;
    else if (op inside {PUSH, DUP} && sz == DEPTH) e = 2'b10;
    else begin
      case (op)
        PUSH: begin rq.push_back(num); n = 1; end
        POP:  begin void'(rq.pop_back()); n = 1; end
        DUP:  begin rq.push_back(rq[$]); n = 1; end
        NEG:  begin rq[$] = 32'd0 - rq[$]; n = 1; end
        SWAP: begin
          a = rq.pop_back();
          b = rq.pop_back();
          rq.push_back(a);
          rq.push_back(b);
          n = 3;
        end
        default: begin
          a = rq.pop_back();
          b = rq.pop_back();
          if (op == ADD) rq.push_back(b + a);
          else if (op == SUB) rq.push_back(b - a);
          else rq.push_back(b * a);
          n = 2;
        end
      endcase
    end
  endtask

  function automatic logic [31:0] ref_top();
    return (rq.size() > 0) ? rq[$] : 32'd0;
  endfunction

  // Issue one command, scramble inputs while busy, wait for done.
  task automatic send(input logic [2:0] op, input logic [31:0] num,
                      output int cyc, output logic [1:0] ec);
    int w;
    w = 0;
    log_q.delete();
    logv_q.delete();
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_num   = num;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 100) begin
      cmd_valid = 1'($urandom);
      cmd_op    = 3'($urandom);
      cmd_num   = $urandom;
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done)
      $display("FAIL done_timeout op=%0d got_done=0 req_done=1", op);
    else passed++;
    ec = err_code;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] num,
                     output int cyc, output logic [1:0] ec,
                     output logic [1:0] xe, output int xn);
    send(op, num, cyc, ec);
    ref_apply(op, num, xe, xn);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0)
      $display("FAIL rst_ready got=%0b req=0", cmd_ready);
    else passed++;
    reset = 1'b0;
    rq.delete();
    @(negedge clk);
    checks++;
    if ({done, err_code} !== 3'b000)
      $display("FAIL rst_done_err got=%b req=000", {done, err_code});
    else passed++;
    checks++;
    if (stk_in_num !== 32'd0)
      $display("FAIL rst_in_num got=%h req=0", stk_in_num);
    else passed++;
    checks++;
    if ({stk_push, stk_pop, stk_replace} !== 3'b000)
      $display("FAIL rst_pulses got=%b req=000",
               {stk_push, stk_pop, stk_replace});
    else passed++;
    checks++;
    if (cmd_ready !== 1'b1)
      $display("FAIL rst_ready_idle got=%0b req=1", cmd_ready);
    else passed++;
  endtask

  task automatic test_sub();
    int c, xn;
    logic [1:0] e, xe;
    do_reset();
    run(PUSH, 32'd7, c, e, xe, xn);
    run(PUSH, 32'd5, c, e, xe, xn);
    run(SUB, 32'd0, c, e, xe, xn);
    checks++;
    if (e !== 2'b00) $display("FAIL sub_err got=%b req=00", e);
    else passed++;
    checks++;
    if (stk_top !== 32'd2) $display("FAIL sub_top got=%0d req=2", stk_top);
    else passed++;
    checks++;
    if (stk_size !== 10'd1)
      $display("FAIL sub_size got=%0d req=1", stk_size);
    else passed++;
  endtask

  task automatic test_swap();
    int c, xn, seq;
    logic [1:0] e, xe;
    do_reset();
    run(PUSH, 32'd3, c, e, xe, xn);
    run(PUSH, 32'd9, c, e, xe, xn);
    run(SWAP, 32'd0, c, e, xe, xn);
    seq = 0;
    foreach (log_q[i]) seq = seq * 4 + log_q[i];
    checks++;
    if (log_q.size() != 3 || seq != 45)
      $display("FAIL swap_order got_n=%0d got_seq=%0d req_n=3 req_seq=45",
               log_q.size(), seq);
    else passed++;
    checks++;
    if (logv_q.size() != 3 || logv_q[1] !== 32'd9 || logv_q[2] !== 32'd3)
      $display("FAIL swap_vals got_n=%0d req=repl9,push3", logv_q.size());
    else passed++;
    run(POP, 32'd0, c, e, xe, xn);
    checks++;
    if (stk_top !== 32'd9 || stk_size !== 10'd1)
      $display("FAIL swap_pop got_top=%0d got_size=%0d req=9,1",
               stk_top, stk_size);
    else passed++;
  endtask

  task automatic test_underflow();
    int c, xn;
    logic [1:0] e, xe;
    do_reset();
    run(ADD, 32'd0, c, e, xe, xn);
    checks++;
    if (e !== 2'b01) $display("FAIL und_add_err got=%b req=01", e);
    else passed++;
    checks++;
    if (log_q.size() != 0)
      $display("FAIL und_add_pulses got=%0d req=0", log_q.size());
    else passed++;
    checks++;
    if (c != 1) $display("FAIL und_add_latency got=%0d req=1", c);
    else passed++;
    run(NEG, 32'd0, c, e, xe, xn);
    checks++;
    if (e !== 2'b01) $display("FAIL und_neg_err got=%b req=01", e);
    else passed++;
    run(PUSH, 32'd5, c, e, xe, xn);
    run(SWAP, 32'd0, c, e, xe, xn);
    checks++;
    if (e !== 2'b01 || stk_top !== 32'd5 || stk_size !== 10'd1)
      $display("FAIL und_swap got_err=%b top=%0d size=%0d req=01,5,1",
               e, stk_top, stk_size);
    else passed++;
  endtask

  task automatic test_latency();
    int c, xn;
    logic [1:0] e, xe;
    do_reset();
    fixed_lat = 1;
    run(PUSH, 32'h1234, c, e, xe, xn);
    checks++;
    if (c != 4) $display("FAIL lat_push got=%0d req=4", c);
    else passed++;
    run(PUSH, 32'h10, c, e, xe, xn);
    run(ADD, 32'd0, c, e, xe, xn);
    checks++;
    if (c != 8) $display("FAIL lat_add got=%0d req=8", c);
    else passed++;
    checks++;
    if (stk_top !== 32'h1244)
      $display("FAIL lat_add_top got=%h req=1244", stk_top);
    else passed++;
    fixed_lat = 0;
  endtask

  task automatic test_overflow();
    int c, xn, bad;
    logic [1:0] e, xe;
    do_reset();
    fixed_lat = 1;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      run(PUSH, $urandom, c, e, xe, xn);
      if (e !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0 || stk_size !== 10'd512 || stk_top !== ref_top())
      $display("FAIL fill got_bad=%0d size=%0d top=%h req=0,512,%h",
               bad, stk_size, stk_top, ref_top());
    else passed++;
    run(PUSH, 32'd1, c, e, xe, xn);
    checks++;
    if (e !== 2'b10 || stk_size !== 10'd512 || log_q.size() != 0)
      $display("FAIL ovf_push got_err=%b size=%0d n=%0d req=10,512,0",
               e, stk_size, log_q.size());
    else passed++;
    run(DUP, 32'd0, c, e, xe, xn);
    checks++;
    if (e !== 2'b10 || stk_size !== 10'd512)
      $display("FAIL ovf_dup got_err=%b size=%0d req=10,512", e, stk_size);
    else passed++;
    fixed_lat = 0;
  endtask

  task automatic test_mul();
    int c, xn;
    logic [1:0] e, xe, req_e;
    logic [9:0] req_sz;
    logic [31:0] req_top;
    req_e   = MUL_EN ? 2'b00 : 2'b11;
    req_sz  = MUL_EN ? 10'd1 : 10'd2;
    req_top = MUL_EN ? 32'hFFFF_FFFE : 32'd2;
    do_reset();
    run(PUSH, 32'hFFFF_FFFF, c, e, xe, xn);
    run(PUSH, 32'd2, c, e, xe, xn);
    run(MUL, 32'd0, c, e, xe, xn);
    checks++;
    if (e !== req_e) $display("FAIL mul_err got=%b req=%b", e, req_e);
    else passed++;
    checks++;
    if (stk_size !== req_sz || stk_top !== req_top)
      $display("FAIL mul_stack got=%0d,%h req=%0d,%h",
               stk_size, stk_top, req_sz, req_top);
    else passed++;
    checks++;
    if (log_q.size() != xn)
      $display("FAIL mul_pulses got=%0d req=%0d", log_q.size(), xn);
    else passed++;
  endtask

  task automatic test_stk_error();
    int c, xn;
    logic [1:0] e, xe;
    do_reset();
    run(PUSH, 32'd10, c, e, xe, xn);
    run(PUSH, 32'd20, c, e, xe, xn);
    inj_err = 1'b1;
    run(ADD, 32'd0, c, e, xe, xn);
    inj_err = 1'b0;
    checks++;
    if (e !== 2'b11 || stk_top !== 32'd30)
      $display("FAIL stkerr got_err=%b top=%0d req=11,30", e, stk_top);
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (err_code !== 2'b11)
      $display("FAIL stkerr_hold got=%b req=11", err_code);
    else passed++;
    run(PUSH, 32'd1, c, e, xe, xn);
    checks++;
    if (e !== 2'b00) $display("FAIL stkerr_clear got=%b req=00", e);
    else passed++;
  endtask

  task automatic test_reset_midop();
    int c, xn, w;
    logic [1:0] e, xe;
    do_reset();
    fixed_lat = 2;
    run(PUSH, 32'd8, c, e, xe, xn);
    run(PUSH, 32'd6, c, e, xe, xn);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = ADD;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!stk_pop && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!stk_pop) $display("FAIL midop_pop got=0 req=1");
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rq.delete();
    #1;
    checks++;
    if ({stk_push, stk_pop, stk_replace, done} !== 4'b0000)
      $display("FAIL midop_quiet got=%b req=0000",
               {stk_push, stk_pop, stk_replace, done});
    else passed++;
    checks++;
    if (stk_size !== 10'd0 || cmd_ready !== 1'b1)
      $display("FAIL midop_idle got_size=%0d ready=%0b req=0,1",
               stk_size, cmd_ready);
    else passed++;
    fixed_lat = 0;
    run(PUSH, 32'd4, c, e, xe, xn);
    checks++;
    if (stk_top !== 32'd4 || stk_size !== 10'd1 || e !== 2'b00)
      $display("FAIL midop_push got=%0d,%0d,%b req=4,1,00",
               stk_top, stk_size, e);
    else passed++;
  endtask

  task automatic test_random();
    int c, xn, r;
    logic [1:0] e, xe;
    logic [2:0] op;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 10));
      op = (r < 4) ? PUSH : 3'(r - 3);
      run(op, $urandom, c, e, xe, xn);
      checks++;
      if (e !== xe)
        $display("FAIL rnd_err i=%0d op=%0d got=%b req=%b", i, op, e, xe);
      else passed++;
      checks++;
      if ({22'd0, stk_size} != 32'(rq.size()))
        $display("FAIL rnd_size i=%0d op=%0d got=%0d req=%0d",
                 i, op, stk_size, rq.size());
      else passed++;
      checks++;
      if (stk_top !== ref_top())
        $display("FAIL rnd_top i=%0d op=%0d got=%h req=%h",
                 i, op, stk_top, ref_top());
      else passed++;
      checks++;
      if (log_q.size() != xn)
        $display("FAIL rnd_ncmd i=%0d op=%0d got=%0d req=%0d",
                 i, op, log_q.size(), xn);
      else passed++;
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol != 0)
      $display("FAIL pulse_protocol got=%0d req=0", viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sub();
    test_swap();
    test_underflow();
    test_latency();
    test_overflow();
    test_mul();
    test_stk_error();
    test_reset_midop();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
